// File: rtl/cpu_pkg.sv
// Shared constants for the 4-bit CPU: ALU codes, instruction opcodes, sequencer states.
// No logic; imported by the control unit and its decoder.
package cpu_pkg;

    localparam logic [2:0] ALU_XOR = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_ADD = 3'b100;
    localparam logic [2:0] ALU_SUB = 3'b110;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_LDI  = 4'h1;
    localparam logic [3:0] OP_ADD  = 4'h2;
    localparam logic [3:0] OP_SUB  = 4'h3;
    localparam logic [3:0] OP_XOR  = 4'h4;
    localparam logic [3:0] OP_AND  = 4'h5;
    localparam logic [3:0] OP_OR   = 4'h6;
    localparam logic [3:0] OP_JMP  = 4'h7;
    localparam logic [3:0] OP_JC   = 4'h8;
    localparam logic [3:0] OP_JZ   = 4'h9;
    localparam logic [3:0] OP_OUT  = 4'hA;
    localparam logic [3:0] OP_HALT = 4'hF;

    typedef enum logic [1:0] {
        S_FETCH,
        S_DECODE,
        S_EXECUTE,
        S_HALT
    } state_t;

    typedef enum logic [1:0] {
        JMP_ALWAYS,
        JMP_CARRY,
        JMP_ZERO
    } jump_cond_t;

endpackage

// File: rtl/cpu_decoder.sv
// Opcode decoder: maps the instruction opcode to ALU code and control qualifiers.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of the opcode.
module cpu_decoder
    import cpu_pkg::*;
(
    input  logic [3:0]  opcode,
    output logic [2:0]  alu_oc,
    output logic        is_alu,
    output logic        updates_carry,
    output logic        is_jump,
    output jump_cond_t  jump_cond,
    output logic        is_out,
    output logic        is_ldi,
    output logic        is_halt
);

    always_comb begin
        alu_oc        = ALU_ADD;
        is_alu        = 1'b0;
        updates_carry = 1'b0;
        is_jump       = 1'b0;
        jump_cond     = JMP_ALWAYS;
        is_out        = 1'b0;
        is_ldi        = 1'b0;
        is_halt       = 1'b0;
        case (opcode)
            OP_LDI:  is_ldi = 1'b1;
            OP_ADD: begin
                is_alu        = 1'b1;
                alu_oc        = ALU_ADD;
                updates_carry = 1'b1;
            end
            OP_SUB: begin
                is_alu        = 1'b1;
                alu_oc        = ALU_SUB;
                updates_carry = 1'b1;
            end
            OP_XOR: begin
                is_alu = 1'b1;
                alu_oc = ALU_XOR;
            end
            OP_AND: begin
                is_alu = 1'b1;
                alu_oc = ALU_AND;
            end
            OP_OR: begin
                is_alu = 1'b1;
                alu_oc = ALU_OR;
            end
            OP_JMP:  is_jump = 1'b1;
            OP_JC: begin
                is_jump   = 1'b1;
                jump_cond = JMP_CARRY;
            end
            OP_JZ: begin
                is_jump   = 1'b1;
                jump_cond = JMP_ZERO;
            end
            OP_OUT:  is_out  = 1'b1;
            OP_HALT: is_halt = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/cpu_control_unit.sv
// Fetch/decode/execute sequencer holding PC, IR, accumulator and C/Z flags.
// Latency: ALU instructions 3 cycles, others 2, plus one per fetch wait cycle.
// Backpressure: stalls in FETCH with imem_req_o held until imem_ack_i.
module cpu_control_unit
    import cpu_pkg::*;
#(
    parameter int DATA_WIDTH = 4,
    parameter int PC_WIDTH   = 4,
    parameter int OC_WIDTH   = 3
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    output logic                  imem_req_o,
    output logic [PC_WIDTH-1:0]   imem_addr_o,
    input  logic                  imem_ack_i,
    input  logic [7:0]            instr_i,
    output logic [DATA_WIDTH-1:0] alu_a_o,
    output logic [DATA_WIDTH-1:0] alu_b_o,
    output logic [OC_WIDTH-1:0]   alu_oc_o,
    input  logic [DATA_WIDTH-1:0] alu_result_i,
    input  logic                  alu_carry_i,
    output logic [DATA_WIDTH-1:0] acc_o,
    output logic                  carry_flag_o,
    output logic                  zero_flag_o,
    output logic [DATA_WIDTH-1:0] out_data_o,
    output logic                  out_valid_o,
    output logic                  halted_o
);

    state_t                state, state_nxt;
    logic [PC_WIDTH-1:0]   pc;
    logic [7:0]            ir;
    logic [DATA_WIDTH-1:0] acc;
    logic                  carry;
    logic                  zero;

    logic [2:0]            dec_alu_oc;
    logic                  dec_is_alu;
    logic                  dec_updates_carry;
    logic                  dec_is_jump;
    jump_cond_t            dec_jump_cond;
    logic                  dec_is_out;
    logic                  dec_is_ldi;
    logic                  dec_is_halt;
    logic                  jump_taken;

    logic [DATA_WIDTH-1:0] imm;
    logic [PC_WIDTH-1:0]   jump_target;

    assign imm         = DATA_WIDTH'(ir[3:0]);
    assign jump_target = PC_WIDTH'(ir[3:0]);

    cpu_decoder u_decoder (
        .opcode        (ir[7:4]),
        .alu_oc        (dec_alu_oc),
        .is_alu        (dec_is_alu),
        .updates_carry (dec_updates_carry),
        .is_jump       (dec_is_jump),
        .jump_cond     (dec_jump_cond),
        .is_out        (dec_is_out),
        .is_ldi        (dec_is_ldi),
        .is_halt       (dec_is_halt)
    );

    always_comb begin
        jump_taken = 1'b0;
        if (dec_is_jump) begin
            case (dec_jump_cond)
                JMP_ALWAYS: jump_taken = 1'b1;
                JMP_CARRY:  jump_taken = carry;
                JMP_ZERO:   jump_taken = zero;
                default:    jump_taken = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= S_FETCH;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_FETCH: begin
                if (imem_ack_i) begin
                    state_nxt = S_DECODE;
                end
            end
            S_DECODE: begin
                if (dec_is_halt) begin
                    state_nxt = S_HALT;
                end else if (dec_is_alu) begin
                    state_nxt = S_EXECUTE;
                end else begin
                    state_nxt = S_FETCH;
                end
            end
            S_EXECUTE: state_nxt = S_FETCH;
            S_HALT:    state_nxt = S_HALT;
            default:   state_nxt = S_FETCH;
        endcase
    end

    // Jump target in DECODE overrides the PC already incremented during FETCH.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pc          <= '0;
            ir          <= '0;
            acc         <= '0;
            carry       <= 1'b0;
            zero        <= 1'b0;
            alu_a_o     <= '0;
            alu_b_o     <= '0;
            alu_oc_o    <= OC_WIDTH'(ALU_ADD);
            out_data_o  <= '0;
            out_valid_o <= 1'b0;
        end else begin
            out_valid_o <= 1'b0;
            case (state)
                S_FETCH: begin
                    if (imem_ack_i) begin
                        ir <= instr_i;
                        pc <= pc + PC_WIDTH'(1);
                    end
                end
                S_DECODE: begin
                    if (dec_is_alu) begin
                        alu_a_o  <= acc;
                        alu_b_o  <= imm;
                        alu_oc_o <= OC_WIDTH'(dec_alu_oc);
                    end
                    if (dec_is_ldi) begin
                        acc  <= imm;
                        zero <= (imm == '0);
                    end
                    if (jump_taken) begin
                        pc <= jump_target;
                    end
                    if (dec_is_out) begin
                        out_data_o  <= acc;
                        out_valid_o <= 1'b1;
                    end
                end
                S_EXECUTE: begin
                    acc  <= alu_result_i;
                    zero <= (alu_result_i == '0);
                    if (dec_updates_carry) begin
                        carry <= alu_carry_i;
                    end
                end
                default: ;
            endcase
        end
    end

    // Request is suppressed while reset is asserted so it reads idle during reset.
    assign imem_req_o   = (state == S_FETCH) && !rst_i;
    assign imem_addr_o  = pc;
    assign halted_o     = (state == S_HALT);
    assign acc_o        = acc;
    assign carry_flag_o = carry;
    assign zero_flag_o  = zero;

endmodule
